alu_unit_p: RTL and testbench

Parametrised successor to the 4-bit processor ALU unit. It is WIDTH-bit and microcode-driven through a 4-bit instruction and a shared tri-state data bus. It keeps the existing register/flag model: operands X1, X2, op-select X3, result R, flags. It adds carry-chained arithmetic (ADC/SBB) and a multi-cycle sequential multiplier with a busy indication and abort. It sits on the processor data bus beside the register file, and the microcode sequencer drives it.

---
 rtl/alu_p_pkg.sv | 57 +++++
 rtl/alu_mul_seq.sv | 89 ++++++++
 rtl/alu_unit_p.sv | 187 ++++++++++++++++++
 tb/tb_alu_unit_p.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_p_pkg.sv
// Shared definitions for the microcoded ALU: opcodes, logic-select codes,
// flag bit positions and the multiplier sequencer state type.
package alu_p_pkg;

    // Instruction opcodes as issued by the microcode sequencer.
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDX1  = 4'h1;
    localparam logic [3:0] OP_LDX2  = 4'h2;
    localparam logic [3:0] OP_LDX3  = 4'h3;
    localparam logic [3:0] OP_LOGIC = 4'h4;
    localparam logic [3:0] OP_ADD   = 4'h5;
    localparam logic [3:0] OP_SUB   = 4'h6;
    localparam logic [3:0] OP_RDR   = 4'h7;
    localparam logic [3:0] OP_RDF   = 4'h8;
    localparam logic [3:0] OP_MVX1  = 4'h9;
    localparam logic [3:0] OP_MVX2  = 4'hA;
    localparam logic [3:0] OP_MUL   = 4'hB;
    localparam logic [3:0] OP_ADC   = 4'hC;
    localparam logic [3:0] OP_SBB   = 4'hD;
    localparam logic [3:0] OP_RDRH  = 4'hE;
    localparam logic [3:0] OP_CLR   = 4'hF;

    // X3 logic-select codes.
    localparam logic [2:0] LG_PASS = 3'd0;
    localparam logic [2:0] LG_AND  = 3'd1;
    localparam logic [2:0] LG_OR   = 3'd2;
    localparam logic [2:0] LG_XOR  = 3'd3;
    localparam logic [2:0] LG_NAND = 3'd4;
    localparam logic [2:0] LG_NOR  = 3'd5;
    localparam logic [2:0] LG_XNOR = 3'd6;
    localparam logic [2:0] LG_NOT  = 3'd7;

    // Bit positions inside the 4-bit flag register {V,N,C,Z}.
    localparam int FL_Z = 0;
    localparam int FL_C = 1;
    localparam int FL_N = 2;
    localparam int FL_V = 3;

    // Multiplier sequencer: idle, or stepping one multiplier bit per cycle.
    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_RUN  = 1'b1
    } mul_state_t;

    // Assemble a flag word from individual flag values.
    function automatic logic [3:0] pack_flags(input logic v, input logic n,
                                              input logic c, input logic z);
        logic [3:0] f;
        f       = 4'b0000;
        f[FL_V] = v;
        f[FL_N] = n;
        f[FL_C] = c;
        f[FL_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per cycle.
//
// Handshake: start is taken on any rising edge where it is high and abort is
// low; operands a/b are captured on that edge. busy stays high for exactly
// WIDTH cycles. done is high during the last of those cycles, and while done
// is high, product already shows the final 2*WIDTH-bit result that the
// accumulator takes on the closing edge. start may be raised during the done
// cycle to chain a new operation without an idle gap. abort (or rst_n low)
// discards everything on the edge where it is seen.
module alu_mul_seq
    import alu_p_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mul_state_t       state_q;
    mul_state_t       state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mplr_q;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic             last_step;

    // One shift-add step: add the multiplicand when the current multiplier bit
    // is set, then shift the {acc, multiplier} pair right by one position.
    always_comb begin
        addend    = mplr_q[0] ? mcand_q : '0;
        sum       = {1'b0, acc_q} + {1'b0, addend};
        product   = {sum, mplr_q[WIDTH-1:1]};
        last_step = (state_q == MS_RUN) && (cnt_q == CW'(WIDTH - 1));
        busy      = (state_q == MS_RUN);
        done      = last_step;
    end

    // State register for the sequencer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: abort wins, then a new start, then natural completion.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = MS_IDLE;
        end else if (start) begin
            state_d = MS_RUN;
        end else if (last_step) begin
            state_d = MS_IDLE;
        end
    end

    // Operand capture, step counter and accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            cnt_q   <= '0;
            mcand_q <= '0;
            acc_q   <= '0;
            mplr_q  <= '0;
        end else if (start) begin
            cnt_q   <= '0;
            mcand_q <= a;
            acc_q   <= '0;
            mplr_q  <= b;
        end else if (state_q == MS_RUN) begin
            cnt_q   <= cnt_q + CW'(1);
            acc_q   <= sum[WIDTH:1];
            mplr_q  <= {sum[0], mplr_q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_unit_p.sv
// WIDTH-bit microcoded ALU on a shared tri-state bus: operand/result register
// file, instruction decoder, single-cycle logic and add/subtract datapath with
// carry chaining, flag logic, bus driver, and a sequential multiplier.
// WIDTH is meant for the range 4..16 (flags need at least 4 bus bits).
module alu_unit_p
    import alu_p_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             grst,
    input  logic [3:0]       instr,
    inout  wire  [WIDTH-1:0] bus,
    output logic             busy
);

    logic [WIDTH-1:0]   x1_q, x2_q, r_q, rh_q;
    logic [2:0]         x3_q;
    logic [3:0]         flags_q;

    logic [WIDTH-1:0]   x1_d, x2_d, r_d, rh_d;
    logic [2:0]         x3_d;
    logic [3:0]         flags_d;

    logic               mul_busy;
    logic               mul_done;
    logic               mul_start;
    logic               mul_abort;
    logic [2*WIDTH-1:0] mul_product;

    logic               exec;
    logic [WIDTH-1:0]   r_cur, rh_cur;
    logic [3:0]         flags_cur;
    logic [WIDTH-1:0]   logic_res;
    logic               arith_cin;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;
    logic               add_v, sub_v;

    logic               drive_en;
    logic [WIDTH-1:0]   bus_out;

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (grst),
        .start   (mul_start),
        .abort   (mul_abort),
        .a       (x1_q),
        .b       (x2_q),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign busy = mul_busy;

    // Decode gating and result forwarding. An instruction executes when no
    // multiply is running, or on the edge where the multiply completes; in
    // that case it must see the multiply's R/RH/flags as if already written.
    always_comb begin
        exec      = !mul_busy || mul_done;
        mul_start = grst && exec && (instr == OP_MUL);
        mul_abort = (instr == OP_CLR);
        if (mul_done) begin
            r_cur     = mul_product[WIDTH-1:0];
            rh_cur    = mul_product[2*WIDTH-1:WIDTH];
            flags_cur = pack_flags(1'b0, 1'b0,
                                   |mul_product[2*WIDTH-1:WIDTH],
                                   ~|mul_product);
        end else begin
            r_cur     = r_q;
            rh_cur    = rh_q;
            flags_cur = flags_q;
        end
    end

    // Logic unit selected by X3; PASS keeps the current R.
    always_comb begin
        logic_res = r_cur;
        case (x3_q)
            LG_AND:  logic_res = x1_q & x2_q;
            LG_OR:   logic_res = x1_q | x2_q;
            LG_XOR:  logic_res = x1_q ^ x2_q;
            LG_NAND: logic_res = ~(x1_q & x2_q);
            LG_NOR:  logic_res = ~(x1_q | x2_q);
            LG_XNOR: logic_res = ~(x1_q ^ x2_q);
            LG_NOT:  logic_res = ~x1_q;
            default: logic_res = r_cur;
        endcase
    end

    // Adder and subtractor with optional carry/borrow-in from the C flag.
    // The extra top bit is carry-out for the add and borrow for the subtract.
    always_comb begin
        arith_cin = ((instr == OP_ADC) || (instr == OP_SBB)) ? flags_cur[FL_C] : 1'b0;
        add_sum   = {1'b0, x1_q} + {1'b0, x2_q} + {{WIDTH{1'b0}}, arith_cin};
        sub_diff  = {1'b0, x1_q} - {1'b0, x2_q} - {{WIDTH{1'b0}}, arith_cin};
        add_v     = (x1_q[WIDTH-1] == x2_q[WIDTH-1]) &&
                    (add_sum[WIDTH-1] != x1_q[WIDTH-1]);
        sub_v     = (x1_q[WIDTH-1] != x2_q[WIDTH-1]) &&
                    (sub_diff[WIDTH-1] != x1_q[WIDTH-1]);
    end

    // Instruction decoder: next values of the register file and flags.
    always_comb begin
        x1_d    = x1_q;
        x2_d    = x2_q;
        x3_d    = x3_q;
        r_d     = r_cur;
        rh_d    = rh_cur;
        flags_d = flags_cur;
        if (exec) begin
            case (instr)
                OP_LDX1: x1_d = bus;
                OP_LDX2: x2_d = bus;
                OP_LDX3: x3_d = bus[2:0];
                OP_LOGIC: begin
                    if (x3_q != LG_PASS) begin
                        r_d     = logic_res;
                        flags_d = pack_flags(1'b0, logic_res[WIDTH-1], 1'b0,
                                             ~|logic_res);
                    end
                end
                OP_ADD, OP_ADC: begin
                    r_d     = add_sum[WIDTH-1:0];
                    flags_d = pack_flags(add_v, add_sum[WIDTH-1], add_sum[WIDTH],
                                         ~|add_sum[WIDTH-1:0]);
                end
                OP_SUB, OP_SBB: begin
                    r_d     = sub_diff[WIDTH-1:0];
                    flags_d = pack_flags(sub_v, sub_diff[WIDTH-1], sub_diff[WIDTH],
                                         ~|sub_diff[WIDTH-1:0]);
                end
                OP_MVX1: x1_d = r_cur;
                OP_MVX2: x2_d = r_cur;
                default: ;
            endcase
        end
    end

    // Register file and flags; reset and CLEAR zero everything.
    always_ff @(posedge clk) begin
        if (!grst || (instr == OP_CLR)) begin
            x1_q    <= '0;
            x2_q    <= '0;
            x3_q    <= '0;
            r_q     <= '0;
            rh_q    <= '0;
            flags_q <= '0;
        end else begin
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            x3_q    <= x3_d;
            r_q     <= r_d;
            rh_q    <= rh_d;
            flags_q <= flags_d;
        end
    end

    // Bus driver: read opcodes drive combinationally when idle and out of reset.
    always_comb begin
        drive_en = 1'b0;
        bus_out  = '0;
        if (grst && !mul_busy) begin
            case (instr)
                OP_RDR: begin
                    drive_en = 1'b1;
                    bus_out  = r_q;
                end
                OP_RDF: begin
                    drive_en = 1'b1;
                    bus_out  = WIDTH'(flags_q);
                end
                OP_RDRH: begin
                    drive_en = 1'b1;
                    bus_out  = rh_q;
                end
                default: ;
            endcase
        end
    end

    assign bus = drive_en ? bus_out : {WIDTH{1'bz}};

endmodule

// File: tb/tb_alu_unit_p.sv
// Bench for alu_unit_p: a 4-bit and an 8-bit instance share clock, reset and
// instruction stream; each has its own bus and its own reference model.
module tb_alu_unit_p;
    import alu_p_pkg::*;

    logic        clk = 1'b0;
    logic        grst;
    logic [3:0]  instr;
    logic        drv_en;
    logic [15:0] drv_val;
    wire  [3:0]  bus4;
    wire  [7:0]  bus8;
    logic        busy4;
    logic        busy8;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state, index 0 = WIDTH 4, index 1 = WIDTH 8.
    logic [15:0] m_x1 [2];
    logic [15:0] m_x2 [2];
    logic [15:0] m_r  [2];
    logic [15:0] m_rh [2];
    logic [15:0] m_pa [2];
    logic [15:0] m_pb [2];
    logic [2:0]  m_x3 [2];
    logic [3:0]  m_fl [2];
    int          m_cnt[2];
    int          m_w  [2] = '{4, 8};

    assign bus4 = drv_en ? drv_val[3:0] : 4'bzzzz;
    assign bus8 = drv_en ? drv_val[7:0] : 8'bzzzzzzzz;

    alu_unit_p #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .grst  (grst),
        .instr (instr),
        .bus   (bus4),
        .busy  (busy4)
    );

    alu_unit_p #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .grst  (grst),
        .instr (instr),
        .bus   (bus8),
        .busy  (busy8)
    );

    always #5 clk = ~clk;

    function automatic int sgn(input logic [15:0] v, input int w);
        if (int'(v) >= (1 << (w - 1))) return int'(v) - (1 << w);
        return int'(v);
    endfunction

    // Behavioural model: applies one sampled instruction to instance i.
    task automatic model_step(input int i);
        int w, mask, p, ua, sr, cin, lo, hi, lv;
        logic bw;
        w    = m_w[i];
        mask = (1 << w) - 1;
        lo   = -(1 << (w - 1));
        hi   = (1 << (w - 1)) - 1;
        if (!grst || instr == OP_CLR) begin
            m_x1[i] = '0; m_x2[i] = '0; m_x3[i] = '0;
            m_r[i]  = '0; m_rh[i] = '0; m_fl[i] = '0;
            m_pa[i] = '0; m_pb[i] = '0; m_cnt[i] = 0;
        end else begin
            if (m_cnt[i] > 0) begin
                m_cnt[i]--;
                if (m_cnt[i] == 0) begin
                    p       = int'(m_pa[i]) * int'(m_pb[i]);
                    m_r[i]  = 16'(p & mask);
                    m_rh[i] = 16'((p >> w) & mask);
                    m_fl[i] = {2'b00, m_rh[i] != 16'h0, p == 0};
                end
            end
            if (m_cnt[i] == 0) begin
                cin = (instr == OP_ADC || instr == OP_SBB) ? int'(m_fl[i][FL_C]) : 0;
                case (instr)
                    OP_LDX1: m_x1[i] = drv_val & 16'(mask);
                    OP_LDX2: m_x2[i] = drv_val & 16'(mask);
                    OP_LDX3: m_x3[i] = drv_val[2:0];
                    OP_LOGIC: begin
                        if (m_x3[i] != 3'd0) begin
                            case (m_x3[i])
                                3'd1: lv = int'(m_x1[i]) & int'(m_x2[i]);
                                3'd2: lv = int'(m_x1[i]) | int'(m_x2[i]);
                                3'd3: lv = int'(m_x1[i]) ^ int'(m_x2[i]);
                                3'd4: lv = ~(int'(m_x1[i]) & int'(m_x2[i]));
                                3'd5: lv = ~(int'(m_x1[i]) | int'(m_x2[i]));
                                3'd6: lv = ~(int'(m_x1[i]) ^ int'(m_x2[i]));
                                default: lv = ~int'(m_x1[i]);
                            endcase
                            m_r[i]  = 16'(lv & mask);
                            m_fl[i] = {1'b0, m_r[i][w-1], 1'b0, m_r[i] == 16'h0};
                        end
                    end
                    OP_ADD, OP_ADC: begin
                        ua      = int'(m_x1[i]) + int'(m_x2[i]) + cin;
                        sr      = sgn(m_x1[i], w) + sgn(m_x2[i], w) + cin;
                        m_r[i]  = 16'(ua & mask);
                        m_fl[i] = {(sr > hi) || (sr < lo), m_r[i][w-1],
                                   ((ua >> w) & 1) != 0, m_r[i] == 16'h0};
                    end
                    OP_SUB, OP_SBB: begin
                        bw      = int'(m_x1[i]) < (int'(m_x2[i]) + cin);
                        ua      = int'(m_x1[i]) - int'(m_x2[i]) - cin;
                        sr      = sgn(m_x1[i], w) - sgn(m_x2[i], w) - cin;
                        m_r[i]  = 16'(ua & mask);
                        m_fl[i] = {(sr > hi) || (sr < lo), m_r[i][w-1], bw,
                                   m_r[i] == 16'h0};
                    end
                    OP_MVX1: m_x1[i] = m_r[i];
                    OP_MVX2: m_x2[i] = m_r[i];
                    OP_MUL: begin
                        m_pa[i]  = m_x1[i];
                        m_pb[i]  = m_x2[i];
                        m_cnt[i] = w;
                    end
                    default: ;
                endcase
            end
        end
    endtask

    // Expected bus for instance i under the current instruction.
    function automatic logic [15:0] exp_bus(input int i);
        logic [15:0] e;
        e = 16'hzzzz;
        if (grst && m_cnt[i] == 0) begin
            case (instr)
                OP_RDR:  e = m_r[i];
                OP_RDF:  e = {12'h000, m_fl[i]};
                OP_RDRH: e = m_rh[i];
                default: ;
            endcase
        end
        if (drv_en) e = drv_val;
        for (int b = m_w[i]; b < 16; b++) e[b] = 1'b0;
        return e;
    endfunction

    function automatic logic [15:0] get_bus(input int i);
        return (i == 0) ? {12'h000, bus4} : {8'h00, bus8};
    endfunction

    function automatic logic get_busy(input int i);
        return (i == 0) ? busy4 : busy8;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [15:0] data);
        grst    = 1'b1;
        instr   = op;
        drv_en  = (op == OP_LDX1) || (op == OP_LDX2) || (op == OP_LDX3);
        drv_val = data;
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic test_reset();
        grst   = 1'b0;
        instr  = OP_RDR;
        drv_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            model_step(0);
            model_step(1);
            #3;
            for (int i = 0; i < 2; i++) begin
                n_total++;
                if (get_bus(i) !== exp_bus(i) || get_busy(i) !== 1'b0) begin
                    $display("FAIL reset_idle[%0d]: bus %h busy %b, required bus %h busy 0",
                             i, get_bus(i), get_busy(i), exp_bus(i));
                end else n_pass++;
            end
        end
        drive(OP_RDR, 16'h0);
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if (get_bus(i) !== 16'h0) begin
                $display("FAIL reset_r[%0d]: got %h required 0000", i, get_bus(i));
            end else n_pass++;
        end
        tick();
        drive(OP_RDF, 16'h0);
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if (get_bus(i) !== 16'h0) begin
                $display("FAIL reset_flags[%0d]: got %h required 0000", i, get_bus(i));
            end else n_pass++;
        end
        tick();
    endtask

    task automatic test_logic();
        logic [3:0] tab_r [7] = '{4'h0, 4'h5, 4'h5, 4'hF, 4'hA, 4'hA, 4'hB};
        drive(OP_LDX1, 16'h4); tick();
        drive(OP_LDX2, 16'h1); tick();
        for (int sel = 1; sel <= 7; sel++) begin
            drive(OP_LDX3, 16'(sel)); tick();
            drive(OP_LOGIC, 16'h0); tick();
            drive(OP_RDR, 16'h0);
            n_total++;
            if (bus4 !== tab_r[sel-1]) begin
                $display("FAIL logic_table sel=%0d: got %h required %h", sel, bus4, tab_r[sel-1]);
            end else n_pass++;
            for (int i = 0; i < 2; i++) begin
                n_total++;
                if (get_bus(i) !== exp_bus(i)) begin
                    $display("FAIL logic_r[%0d] sel=%0d: got %h required %h",
                             i, sel, get_bus(i), exp_bus(i));
                end else n_pass++;
            end
            tick();
            drive(OP_RDF, 16'h0);
            for (int i = 0; i < 2; i++) begin
                n_total++;
                if (get_bus(i) !== exp_bus(i)) begin
                    $display("FAIL logic_flags[%0d] sel=%0d: got %h required %h",
                             i, sel, get_bus(i), exp_bus(i));
                end else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_arith();
        logic [15:0] ax1 [5] = '{16'h07, 16'h01, 16'h00, 16'hFF, 16'h00};
        logic [15:0] ax2 [5] = '{16'h01, 16'h02, 16'h00, 16'h01, 16'h00};
        logic [3:0]  aop [5] = '{OP_ADD, OP_SUB, OP_ADC, OP_ADD, OP_ADC};
        int          ci  [5] = '{0, 0, 0, 1, 1};
        logic [15:0] cr  [5] = '{16'h08, 16'h0F, 16'h01, 16'h00, 16'h01};
        logic [15:0] cf  [5] = '{16'hC, 16'h6, 16'h0, 16'h3, 16'h0};
        for (int s = 0; s < 5; s++) begin
            drive(OP_LDX1, ax1[s]); tick();
            drive(OP_LDX2, ax2[s]); tick();
            drive(aop[s], 16'h0); tick();
            drive(OP_RDR, 16'h0);
            n_total++;
            if (get_bus(ci[s]) !== cr[s]) begin
                $display("FAIL arith_const_r step %0d: got %h required %h", s, get_bus(ci[s]), cr[s]);
            end else n_pass++;
            for (int i = 0; i < 2; i++) begin
                n_total++;
                if (get_bus(i) !== exp_bus(i)) begin
                    $display("FAIL arith_r[%0d] step %0d: got %h required %h",
                             i, s, get_bus(i), exp_bus(i));
                end else n_pass++;
            end
            tick();
            drive(OP_RDF, 16'h0);
            n_total++;
            if (get_bus(ci[s]) !== cf[s]) begin
                $display("FAIL arith_const_flags step %0d: got %h required %h", s, get_bus(ci[s]), cf[s]);
            end else n_pass++;
            for (int i = 0; i < 2; i++) begin
                n_total++;
                if (get_bus(i) !== exp_bus(i)) begin
                    $display("FAIL arith_flags[%0d] step %0d: got %h required %h",
                             i, s, get_bus(i), exp_bus(i));
                end else n_pass++;
            end
            tick();
        end
    endtask

    task automatic test_mul();
        logic [15:0] mx1 [2] = '{16'h00FF, 16'h00C8};
        logic [15:0] mx2 [2] = '{16'h00FF, 16'h0003};
        int          ci  [2] = '{0, 1};
        logic [15:0] cr  [2] = '{16'h01, 16'h58};
        logic [15:0] crh [2] = '{16'h0E, 16'h02};
        logic [3:0]  op;
        int c4, c8;
        for (int s = 0; s < 2; s++) begin
            drive(OP_LDX1, mx1[s]); tick();
            drive(OP_LDX2, mx2[s]); tick();
            drive(OP_MUL, 16'h0); tick();
            c4 = 0;
            c8 = 0;
            for (int k = 0; k < 12; k++) begin
                op = (k == 0 || k == 2) ? OP_LDX1 : (k == 1) ? OP_RDR : OP_NOP;
                drive(op, 16'($urandom));
                if (busy4 === 1'b1) c4++;
                if (busy8 === 1'b1) c8++;
                for (int i = 0; i < 2; i++) begin
                    n_total++;
                    if (get_bus(i) !== exp_bus(i) || get_busy(i) !== (m_cnt[i] > 0)) begin
                        $display("FAIL mul_run[%0d] case %0d cyc %0d: bus %h busy %b, required bus %h busy %b",
                                 i, s, k, get_bus(i), get_busy(i), exp_bus(i), m_cnt[i] > 0);
                    end else n_pass++;
                end
                tick();
            end
            n_total++;
            if (c4 != 4 || c8 != 8) begin
                $display("FAIL mul_busy_len case %0d: got %0d/%0d cycles required 4/8", s, c4, c8);
            end else n_pass++;
            drive(OP_RDR, 16'h0);
            n_total++;
            if (get_bus(ci[s]) !== cr[s] || get_bus(0) !== exp_bus(0) || get_bus(1) !== exp_bus(1)) begin
                $display("FAIL mul_r case %0d: got %h/%h required %h/%h", s,
                         get_bus(0), get_bus(1), exp_bus(0), exp_bus(1));
            end else n_pass++;
            tick();
            drive(OP_RDRH, 16'h0);
            n_total++;
            if (get_bus(ci[s]) !== crh[s] || get_bus(0) !== exp_bus(0) || get_bus(1) !== exp_bus(1)) begin
                $display("FAIL mul_rh case %0d: got %h/%h required %h/%h", s,
                         get_bus(0), get_bus(1), exp_bus(0), exp_bus(1));
            end else n_pass++;
            tick();
            drive(OP_RDF, 16'h0);
            n_total++;
            if (get_bus(ci[s]) !== 16'h2 || get_bus(0) !== exp_bus(0) || get_bus(1) !== exp_bus(1)) begin
                $display("FAIL mul_flags case %0d: got %h/%h required %h/%h", s,
                         get_bus(0), get_bus(1), exp_bus(0), exp_bus(1));
            end else n_pass++;
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int c4;
        drive(OP_LDX1, 16'h9); tick();
        drive(OP_LDX2, 16'h9); tick();
        drive(OP_MUL, 16'h0); tick();
        for (int k = 0; k < 3; k++) begin
            drive(OP_NOP, 16'h0); tick();
        end
        drive(OP_MUL, 16'h0);
        n_total++;
        if (busy4 !== 1'b1) begin
            $display("FAIL b2b_busy_before: got %b required 1", busy4);
        end else n_pass++;
        tick();
        c4 = 0;
        for (int k = 0; k < 12; k++) begin
            drive(OP_NOP, 16'h0);
            if (busy4 === 1'b1) c4++;
            for (int i = 0; i < 2; i++) begin
                n_total++;
                if (get_busy(i) !== (m_cnt[i] > 0)) begin
                    $display("FAIL b2b_busy[%0d] cyc %0d: got %b required %b",
                             i, k, get_busy(i), m_cnt[i] > 0);
                end else n_pass++;
            end
            tick();
        end
        n_total++;
        if (c4 != 4) begin
            $display("FAIL b2b_restart_len: got %0d cycles required 4", c4);
        end else n_pass++;
        drive(OP_ADC, 16'h0); tick();
        drive(OP_RDR, 16'h0);
        n_total++;
        if (bus4 !== 4'h3 || get_bus(0) !== exp_bus(0) || get_bus(1) !== exp_bus(1)) begin
            $display("FAIL b2b_adc_r: got %h/%h required 3/%h", get_bus(0), get_bus(1), exp_bus(1));
        end else n_pass++;
        tick();
    endtask

    task automatic test_abort();
        for (int rep = 0; rep < 2; rep++) begin
            drive(OP_LDX1, 16'h9); tick();
            drive(OP_LDX2, 16'h9); tick();
            drive(OP_MUL, 16'h0); tick();
            drive(OP_NOP, 16'h0); tick();
            if (rep == 0) begin
                drive(OP_CLR, 16'h0); tick();
            end else begin
                drive(OP_NOP, 16'h0); tick();
                drive(OP_NOP, 16'h0);
                grst = 1'b0;
                tick();
            end
            drive(OP_NOP, 16'h0);
            for (int i = 0; i < 2; i++) begin
                n_total++;
                if (get_busy(i) !== 1'b0 || m_cnt[i] != 0) begin
                    $display("FAIL abort_busy[%0d] rep %0d: got %b required 0", i, rep, get_busy(i));
                end else n_pass++;
            end
            for (int r = 0; r < 3; r++) begin
                drive((r == 0) ? OP_RDR : (r == 1) ? OP_RDRH : OP_RDF, 16'h0);
                for (int i = 0; i < 2; i++) begin
                    n_total++;
                    if (get_bus(i) !== 16'h0 || get_bus(i) !== exp_bus(i)) begin
                        $display("FAIL abort_zero[%0d] rep %0d read %0d: got %h required 0000",
                                 i, rep, r, get_bus(i));
                    end else n_pass++;
                end
                tick();
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int k = 0; k < 250; k++) begin
            op = 4'($urandom_range(0, 15));
            if (op == OP_CLR && $urandom_range(0, 3) != 0) op = OP_MUL;
            drive(op, 16'($urandom));
            for (int i = 0; i < 2; i++) begin
                n_total++;
                if (get_bus(i) !== exp_bus(i) || get_busy(i) !== (m_cnt[i] > 0)) begin
                    $display("FAIL random[%0d] cyc %0d op %h: bus %h busy %b, required bus %h busy %b",
                             i, k, op, get_bus(i), get_busy(i), exp_bus(i), m_cnt[i] > 0);
                end else n_pass++;
            end
            tick();
        end
    endtask

    initial begin
        grst    = 1'b0;
        instr   = OP_NOP;
        drv_en  = 1'b0;
        drv_val = 16'h0;
        for (int i = 0; i < 2; i++) begin
            m_x1[i] = '0; m_x2[i] = '0; m_x3[i] = '0; m_r[i] = '0;
            m_rh[i] = '0; m_fl[i] = '0; m_pa[i] = '0; m_pb[i] = '0;
            m_cnt[i] = 0;
        end
        test_reset();
        test_logic();
        test_arith();
        test_mul();
        test_back_to_back();
        test_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
